// File: rtl/seg_codes_pkg.sv
// Character codes, frame constants and scroller state type shared by the
// 7-segment display blocks.
package seg_codes_pkg;

  localparam int CHAR_W   = 5;
  localparam int N_DIGITS = 4;
  localparam int FRAME_W  = CHAR_W * N_DIGITS;

  localparam logic [CHAR_W-1:0] CHAR_BLANK  = 5'd31;
  localparam logic [CHAR_W-1:0] CHAR_HYPHEN = 5'd10;
  localparam logic [CHAR_W-1:0] CHAR_E      = 5'd11;
  localparam logic [CHAR_W-1:0] CHAR_R      = 5'd12;
  localparam logic [CHAR_W-1:0] CHAR_L      = 5'd13;
  localparam logic [CHAR_W-1:0] CHAR_H      = 5'd14;
  localparam logic [CHAR_W-1:0] CHAR_U      = 5'd15;
  localparam logic [CHAR_W-1:0] CHAR_P      = 5'd16;
  localparam logic [CHAR_W-1:0] CHAR_O      = 5'd17;
  localparam logic [CHAR_W-1:0] CHAR_B      = 5'd18;
  localparam logic [CHAR_W-1:0] CHAR_D      = 5'd19;
  localparam logic [CHAR_W-1:0] CHAR_N      = 5'd20;
  localparam logic [CHAR_W-1:0] CHAR_J      = 5'd21;
  localparam logic [CHAR_W-1:0] CHAR_Y      = 5'd22;

  localparam logic [FRAME_W-1:0] BLANK_FRAME = 20'hFFFFF;

  typedef enum logic {
    IDLE,
    SCROLL
  } scroll_state_t;

endpackage

// File: rtl/seg_step_tick.sv
// Divide-by-TICK_DIV counter that emits a one-cycle step strobe on the last
// count while enabled.
module seg_step_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_step
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] r_tick;

  assign o_step = i_enable && (r_tick == TICK_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_tick <= '0;
    end else if (i_enable) begin
      if (o_step) begin
        r_tick <= '0;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_msg_scroller.sv
// Feeds the 4-digit display: passes an idle pattern through, or scrolls a
// latched message right-to-left and pulses done once it has fully exited.
module seg_msg_scroller
  import seg_codes_pkg::*;
#(
  parameter int MSG_LEN  = 8,
  parameter int TICK_DIV = 25_000_000,
  parameter int LEN_W    = $clog2(MSG_LEN + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [FRAME_W-1:0]          i_idle_data,
  input  logic                        i_msg_valid,
  output logic                        o_msg_ready,
  input  logic [CHAR_W*MSG_LEN-1:0]   i_msg_text,
  input  logic [LEN_W-1:0]            i_msg_len,
  input  logic                        i_abort,
  output logic [FRAME_W-1:0]          o_seg_data,
  output logic                        o_busy,
  output logic                        o_done
);

  // pos runs to len+4 after the final step, so it needs room beyond MSG_LEN
  localparam int POS_W = $clog2(MSG_LEN + 5);

  scroll_state_t     r_state;
  scroll_state_t     w_nextState;
  logic [FRAME_W-1:0] r_seg;
  logic [FRAME_W-1:0] w_nextSeg;
  logic              r_done;
  logic              w_nextDone;
  logic [CHAR_W-1:0] r_msgBuf [MSG_LEN];
  logic [POS_W-1:0]  r_msgLen;
  logic [POS_W-1:0]  r_pos;
  logic [LEN_W-1:0]  w_lenClamped;
  logic              w_accept;
  logic              w_loadBuf;
  logic              w_posClear;
  logic              w_posInc;
  logic              w_step;
  logic              w_lastStep;
  logic [CHAR_W-1:0] w_bufChar;
  logic [CHAR_W-1:0] w_char;

  assign o_msg_ready  = (r_state == IDLE);
  assign o_busy       = (r_state == SCROLL);
  assign o_done       = r_done;
  assign o_seg_data   = r_seg;
  assign w_accept     = i_msg_valid && o_msg_ready;
  assign w_lenClamped = (i_msg_len > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : i_msg_len;
  assign w_lastStep   = (r_pos == r_msgLen + POS_W'(3));

  seg_step_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_accept),
    .i_enable (r_state == SCROLL),
    .o_step   (w_step)
  );

  // Past the end of the message the blank character is shifted in
  always_comb begin
    w_bufChar = CHAR_BLANK;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (r_pos == POS_W'(i)) begin
        w_bufChar = r_msgBuf[i];
      end
    end
    w_char = (r_pos < r_msgLen) ? w_bufChar : CHAR_BLANK;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_seg   <= BLANK_FRAME;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_seg   <= w_nextSeg;
      r_done  <= w_nextDone;
    end
  end

  // Abort takes priority over a step landing on the same edge
  always_comb begin
    w_nextState = r_state;
    w_nextSeg   = r_seg;
    w_nextDone  = 1'b0;
    w_loadBuf   = 1'b0;
    w_posClear  = 1'b0;
    w_posInc    = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextSeg = i_idle_data;
        if (w_accept) begin
          w_loadBuf  = 1'b1;
          w_posClear = 1'b1;
          if (w_lenClamped != '0) begin
            w_nextState = SCROLL;
            w_nextSeg   = BLANK_FRAME;
          end else begin
            w_nextDone = 1'b1;
          end
        end
      end
      SCROLL: begin
        if (i_abort) begin
          w_nextState = IDLE;
          w_nextSeg   = i_idle_data;
        end else if (w_step) begin
          w_nextSeg = {r_seg[FRAME_W-CHAR_W-1:0], w_char};
          w_posInc  = 1'b1;
          if (w_lastStep) begin
            w_nextState = IDLE;
            w_nextDone  = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_posClear) begin
      r_pos <= '0;
    end else if (w_posInc) begin
      r_pos <= r_pos + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_msgLen <= '0;
      for (int i = 0; i < MSG_LEN; i++) begin
        r_msgBuf[i] <= CHAR_BLANK;
      end
    end else if (w_loadBuf) begin
      r_msgLen <= POS_W'(w_lenClamped);
      for (int i = 0; i < MSG_LEN; i++) begin
        r_msgBuf[i] <= i_msg_text[i*CHAR_W +: CHAR_W];
      end
    end
  end

endmodule
